// File: rtl/pwm_average_driver_if.sv
// Signal bundle for pwm_average_driver: run request, tap bus, and PWM/average outputs.
// avg_valid is a one-cycle strobe with no ready: consumers must sample it on the cycle it is high.
interface pwm_average_driver_if #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 8
);
  logic                    enable;
  logic [WIDTH*SIZE-1:0]   taps_flat;
  logic                    pwm_out;
  logic [WIDTH-1:0]        duty_out;
  logic                    avg_valid;
  logic                    busy;
  logic [1:0]              state_dbg;

  modport master (
    output enable, taps_flat,
    input  pwm_out, duty_out, avg_valid, busy, state_dbg
  );

  modport slave (
    input  enable, taps_flat,
    output pwm_out, duty_out, avg_valid, busy, state_dbg
  );
endinterface

// File: rtl/pwm_average_driver.sv
// Snapshots the tap register at each PWM period start, averages it one tap per cycle,
// and applies the average as the next period's duty cycle.
module pwm_average_driver #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pwm_average_driver_if.slave  bus
);
  localparam int IW = $clog2(SIZE);
  localparam int AW = WIDTH + IW;
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [IW-1:0]    IDX_LAST = IW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] snap_q [SIZE];
  logic [WIDTH-1:0] snap_d [SIZE];
  logic [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] duty_pending_q, duty_pending_d;
  logic [WIDTH-1:0] duty_active_q, duty_active_d;
  logic             avg_valid_q, avg_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      run_q          <= 1'b0;
      cnt_q          <= '0;
      acc_q          <= '0;
      idx_q          <= '0;
      duty_pending_q <= '0;
      duty_active_q  <= '0;
      avg_valid_q    <= 1'b0;
      for (int i = 0; i < SIZE; i++) snap_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      duty_pending_q <= duty_pending_d;
      duty_active_q  <= duty_active_d;
      avg_valid_q    <= avg_valid_d;
      for (int i = 0; i < SIZE; i++) snap_q[i] <= snap_d[i];
    end
  end

  always_comb begin
    run_d          = bus.enable;
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    duty_pending_d = duty_pending_q;
    duty_active_d  = duty_active_q;
    avg_valid_d    = 1'b0;
    for (int i = 0; i < SIZE; i++) snap_d[i] = snap_q[i];

    // Dropping enable aborts immediately; the duty registers are deliberately left alone.
    if (!bus.enable) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (!run_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
      if (cnt_q == CNT_MAX) duty_active_d = duty_pending_q;
      unique case (state_q)
        IDLE: begin
          if (cnt_q == '0) begin
            state_d = ACCUM;
            acc_d   = '0;
            idx_d   = '0;
            for (int i = 0; i < SIZE; i++) snap_d[i] = bus.taps_flat[i*WIDTH +: WIDTH];
          end
        end
        ACCUM: begin
          acc_d = acc_q + AW'(snap_q[idx_q]);
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) state_d = DONE;
        end
        DONE: begin
          // Dropping the low IW bits is the truncating divide by SIZE.
          duty_pending_d = acc_q[AW-1:IW];
          avg_valid_d    = 1'b1;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.pwm_out   = run_q && (cnt_q < duty_active_q);
  assign bus.duty_out  = duty_active_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;
endmodule
